// File: rtl/custom_timings.sv
// Frame geometry and shared types for the super-high-resolution VRAM writer.
// Frame size in 32-bit words drives the write-address wrap point.
package custom_timings;

    typedef struct packed {
        logic [16:0] addr;
        logic [23:0] rgb;
    } shr_wr_entry_t;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } shr_data_phase_t;

    function automatic logic [16:0] PIXEL_WIDTH();
        return 17'd512;
    endfunction

    function automatic logic [16:0] PIXEL_HEIGHT(input logic pal_mode);
        return pal_mode ? 17'd576 : 17'd480;
    endfunction

    // One word holds a 4x4 pixel super-pixel, hence the divide by 4 on each axis.
    function automatic logic [16:0] SHR_FRAME_WORDS(input logic pal_mode);
        return (PIXEL_WIDTH() >> 2) * (PIXEL_HEIGHT(pal_mode) >> 2);
    endfunction

endpackage

// File: rtl/vdp_shr_write_fifo.sv
// Small power-of-two FIFO of pending VRAM writes with a combinational head.
// A push is accepted when full only if a pop happens in the same cycle.
module vdp_shr_write_fifo
    import custom_timings::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        i_srst,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [40:0] i_push_data,
    input  logic        i_pop,
    output logic        o_full,
    output logic        o_empty,
    output logic [40:0] o_head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    shr_wr_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_pop;
    logic               w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_COUNT);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/vdp_super_high_res_writer.sv
// Host byte-port to VRAM write path for super-high-res mode: assembles R,G,B into words.
// Optional sticky drop flag enabled by SUPER_HIGH_RES_WRITER_OVERFLOW_EN.
module vdp_super_high_res_writer
    import custom_timings::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        super_high_res,
    input  logic        pal_mode,
    input  logic        cpu_wr,
    input  logic        cpu_port,
    input  logic [7:0]  cpu_data,
    output logic        busy,
    output logic        vram_wr_req,
    output logic [16:0] vram_wr_addr,
    output logic [31:0] vram_wr_data,
`ifdef SUPER_HIGH_RES_WRITER_OVERFLOW_EN
    output logic        overflow,
`endif
    input  logic        vram_wr_ack
);
    shr_data_phase_t r_data_phase;
    shr_data_phase_t w_data_phase_next;
    logic [1:0]      r_addr_phase;
    logic [16:0]     r_wr_addr;
    logic [7:0]      r_red;
    logic [7:0]      r_green;

    logic            w_addr_wr;
    logic            w_data_wr;
    logic            w_push;
    logic            w_load_r;
    logic            w_load_g;
    logic            w_full;
    logic            w_empty;
    logic [16:0]     w_addr_inc;
    logic [16:0]     w_addr_next;
    shr_wr_entry_t   w_push_entry;
    shr_wr_entry_t   w_head_entry;

    assign w_addr_wr = super_high_res & cpu_wr & cpu_port;
    assign w_data_wr = super_high_res & cpu_wr & ~cpu_port;

    always_ff @(posedge clk) begin
        if (reset) r_data_phase <= PH_R;
        else       r_data_phase <= w_data_phase_next;
    end

    always_comb begin
        w_data_phase_next = r_data_phase;
        if (!super_high_res || w_addr_wr) begin
            w_data_phase_next = PH_R;
        end else if (w_data_wr) begin
            case (r_data_phase)
                PH_R:    w_data_phase_next = PH_G;
                PH_G:    w_data_phase_next = PH_B;
                default: w_data_phase_next = PH_R;
            endcase
        end
    end

    always_comb begin
        w_load_r = 1'b0;
        w_load_g = 1'b0;
        w_push   = 1'b0;
        if (w_data_wr) begin
            case (r_data_phase)
                PH_R:    w_load_r = 1'b1;
                PH_G:    w_load_g = 1'b1;
                default: w_push   = 1'b1;
            endcase
        end
    end

    // Wrap exactly at the end of the current frame, not at the 17-bit boundary.
    assign w_addr_inc  = r_wr_addr + 17'd2;
    assign w_addr_next = (w_addr_inc == (SHR_FRAME_WORDS(pal_mode) << 1)) ? '0 : w_addr_inc;

    always_ff @(posedge clk) begin
        if (reset || !super_high_res) begin
            r_addr_phase <= 2'd0;
        end else if (w_addr_wr) begin
            r_addr_phase <= (r_addr_phase == 2'd2) ? 2'd0 : r_addr_phase + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_addr <= '0;
            r_red     <= '0;
            r_green   <= '0;
        end else begin
            if (w_load_r) r_red   <= cpu_data;
            if (w_load_g) r_green <= cpu_data;
            if (w_addr_wr) begin
                case (r_addr_phase)
                    2'd0:    r_wr_addr[7:0]  <= cpu_data;
                    2'd1:    r_wr_addr[15:8] <= cpu_data;
                    default: r_wr_addr[16]   <= cpu_data[0];
                endcase
            end else if (w_push) begin
                r_wr_addr <= w_addr_next;
            end
        end
    end

    assign w_push_entry = '{addr: r_wr_addr, rgb: {r_red, r_green, cpu_data}};

    vdp_shr_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .i_srst      (reset),
        .i_flush     (~super_high_res),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (vram_wr_ack),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head_entry)
    );

    // Outputs read as zero when nothing is pending so reset leaves a clean bus.
    assign busy         = w_full;
    assign vram_wr_req  = ~w_empty;
    assign vram_wr_addr = w_empty ? '0 : w_head_entry.addr;
    assign vram_wr_data = w_empty ? '0 : {8'h00, w_head_entry.rgb};

`ifdef SUPER_HIGH_RES_WRITER_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_addr_wr) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !(vram_wr_ack && !w_empty)) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif
endmodule

// File: tb/tb_vdp_super_high_res_writer.sv
// Directed bench for vdp_super_high_res_writer: queue-based model checked every cycle
// plus literal expectations for the key scenarios.
module tb_vdp_super_high_res_writer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, shr, pal, cpu_wr, cpu_port, ack;
    logic [7:0]  cpu_data;
    logic        busy, req;
    logic [16:0] waddr;
    logic [31:0] wdata;
`ifdef SUPER_HIGH_RES_WRITER_OVERFLOW_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    vdp_super_high_res_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .super_high_res (shr),
        .pal_mode       (pal),
        .cpu_wr         (cpu_wr),
        .cpu_port       (cpu_port),
        .cpu_data       (cpu_data),
        .busy           (busy),
        .vram_wr_req    (req),
        .vram_wr_addr   (waddr),
        .vram_wr_data   (wdata),
`ifdef SUPER_HIGH_RES_WRITER_OVERFLOW_EN
        .overflow       (overflow),
`endif
        .vram_wr_ack    (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_addr[$];
    int m_data[$];
    int m_wr_addr = 0, m_aph = 0, m_dph = 0, m_r = 0, m_g = 0;
    bit m_ovf = 1'b0;

    function automatic int frame_wrap(input bit p);
        return (512 / 4) * ((p ? 576 : 480) / 4) * 2;
    endfunction

    always @(posedge clk) begin
        bit pop, push;
        int pa, pd, nxt;
        pop = 0; push = 0; pa = 0; pd = 0;
        if (reset) begin
            m_addr.delete(); m_data.delete();
            m_wr_addr = 0; m_aph = 0; m_dph = 0; m_r = 0; m_g = 0; m_ovf = 0;
        end else if (!shr) begin
            m_addr.delete(); m_data.delete();
            m_aph = 0; m_dph = 0;
        end else begin
            pop = ack && (m_addr.size() > 0);
            if (cpu_wr && cpu_port) begin
                case (m_aph)
                    0: m_wr_addr = (m_wr_addr & 'h1FF00) | int'(cpu_data);
                    1: m_wr_addr = (m_wr_addr & 'h100FF) | (int'(cpu_data) << 8);
                    default: m_wr_addr = (m_wr_addr & 'h0FFFF) | ((int'(cpu_data) & 1) << 16);
                endcase
                m_aph = (m_aph + 1) % 3;
                m_dph = 0;
                m_ovf = 0;
            end else if (cpu_wr) begin
                case (m_dph)
                    0: m_r = int'(cpu_data);
                    1: m_g = int'(cpu_data);
                    default: begin
                        if (m_addr.size() < DEPTH || pop) begin
                            push = 1; pa = m_wr_addr;
                            pd = (m_r << 16) | (m_g << 8) | int'(cpu_data);
                        end else begin
                            m_ovf = 1;
                        end
                        nxt = m_wr_addr + 2;
                        m_wr_addr = (nxt == frame_wrap(pal)) ? 0 : (nxt & 'h1FFFF);
                    end
                endcase
                m_dph = (m_dph + 1) % 3;
            end
            if (pop) begin void'(m_addr.pop_front()); void'(m_data.pop_front()); end
            if (push) begin m_addr.push_back(pa); m_data.push_back(pd); end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_req", int'(req), int'(m_addr.size() != 0));
            chk("model_busy", int'(busy), int'(m_addr.size() == DEPTH));
            if (m_addr.size() != 0) begin
                chk("model_addr", int'(waddr), m_addr[0]);
                chk("model_data", int'(wdata), m_data[0]);
            end
`ifdef SUPER_HIGH_RES_WRITER_OVERFLOW_EN
            chk("model_overflow", int'(overflow), int'(m_ovf));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wr(input bit p, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_port = p; cpu_data = d;
        cyc();
        cpu_wr = 1'b0;
    endtask

    task automatic set_addr(input int a);
        wr(1'b1, a[7:0]); wr(1'b1, a[15:8]); wr(1'b1, {7'd0, a[16]});
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        wr(1'b0, r); wr(1'b0, g); wr(1'b0, b);
    endtask

    task automatic drain_expect(input int exp_addr);
        chk("drain_req", int'(req), 1);
        chk("drain_addr", int'(waddr), exp_addr);
        ack = 1'b1; cyc(); ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; shr = 1'b1; pal = 1'b0; cpu_wr = 1'b0;
        cpu_port = 1'b0; cpu_data = 8'h00; ack = 1'b0;
        cyc();
        cmp_en = 1'b1;
        cyc();
        chk("reset_req", int'(req), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_addr", int'(waddr), 0);
        chk("reset_data", int'(wdata), 0);
        reset = 1'b0;
        cyc();
        $display("txn: reset done");

        // basic write, ack after three held cycles
        set_addr('h00000);
        pix(8'h12, 8'h34, 8'h56);
        for (int i = 0; i < 3; i++) begin
            chk("basic_req", int'(req), 1);
            chk("basic_addr", int'(waddr), 'h00000);
            chk("basic_data", int'(wdata), 'h00123456);
            if (i == 2) ack = 1'b1;
            cyc();
        end
        ack = 1'b0;
        chk("basic_req_after_ack", int'(req), 0);
        $display("txn: basic pixel 0x00123456 at 0x00000");

        // NTSC frame wrap
        set_addr('h077FE);
        pix(8'h01, 8'h02, 8'h03); pix(8'h04, 8'h05, 8'h06);
        drain_expect('h077FE); drain_expect('h00000);
        $display("txn: ntsc wrap 0x077FE -> 0x00000");

        // PAL does not wrap at the NTSC boundary, then wraps at its own
        set_addr('h077FE); pal = 1'b1;
        pix(8'h07, 8'h08, 8'h09); pix(8'h0A, 8'h0B, 8'h0C);
        drain_expect('h077FE); drain_expect('h07800);
        set_addr('h08FFE);
        pix(8'h11, 8'h22, 8'h33); pix(8'h44, 8'h55, 8'h66);
        drain_expect('h08FFE); drain_expect('h00000);
        pal = 1'b0;
        $display("txn: pal wrap 0x08FFE -> 0x00000");

        // overflow: six pixels, no ack
        set_addr('h00000);
        for (int i = 0; i < 6; i++) begin
            pix(8'(i), 8'(i + 1), 8'(i + 2));
            if (i == 2) chk("fill_busy_3", int'(busy), 0);
            if (i == 3) chk("fill_busy_4", int'(busy), 1);
        end
`ifdef SUPER_HIGH_RES_WRITER_OVERFLOW_EN
        chk("overflow_set", int'(overflow), 1);
`endif
        drain_expect(0); drain_expect(2); drain_expect(4); drain_expect(6);
        chk("overflow_drained", int'(req), 0);
        pix(8'hE0, 8'hE1, 8'hE2);
        drain_expect('h0000C);
        $display("txn: overflow drop, next address 0x0000C");

        // full FIFO with push coinciding with pop
        set_addr('h00000);
        for (int i = 0; i < 4; i++) pix(8'h10, 8'h20, 8'(i));
        chk("full_busy", int'(busy), 1);
        wr(1'b0, 8'h70); wr(1'b0, 8'h71);
        cpu_wr = 1'b1; cpu_port = 1'b0; cpu_data = 8'h72; ack = 1'b1;
        cyc();
        cpu_wr = 1'b0; ack = 1'b0;
        chk("push_pop_busy", int'(busy), 1);
`ifdef SUPER_HIGH_RES_WRITER_OVERFLOW_EN
        chk("push_pop_overflow", int'(overflow), 0);
`endif
        drain_expect(2); drain_expect(4); drain_expect(6);
        chk("push_pop_last_data", int'(wdata), 'h00707172);
        drain_expect(8);
        $display("txn: push+pop while full");

        // address write discards partial R,G
        wr(1'b0, 8'h11); wr(1'b0, 8'h22);
        set_addr('h00010);
        pix(8'hAA, 8'hBB, 8'hCC);
        chk("phase_clear_data", int'(wdata), 'h00AABBCC);
        drain_expect('h00010);
        $display("txn: phase clear 0x00AABBCC at 0x00010");

        // mode drop keeps wr_addr and ignores writes
        set_addr('h00020);
        pix(8'h01, 8'h01, 8'h01); pix(8'h02, 8'h02, 8'h02);
        shr = 1'b0;
        cyc();
        chk("mode_drop_req", int'(req), 0);
        chk("mode_drop_busy", int'(busy), 0);
        wr(1'b0, 8'h99);
        shr = 1'b1;
        pix(8'h03, 8'h04, 8'h05);
        chk("mode_resume_data", int'(wdata), 'h00030405);
        drain_expect('h00024);
        $display("txn: mode drop, resume at 0x00024");

        // reset during pending request clears wr_addr
        pix(8'h06, 8'h06, 8'h06);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("reset_mid_req", int'(req), 0);
        pix(8'h07, 8'h08, 8'h09);
        drain_expect('h00000);
        chk("reset_final_req", int'(req), 0);
        $display("txn: reset mid-request, resume at 0x00000");

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
